instruction_fetch: RTL

//  Fetch stage upstream of controlunit: walks a flat program image with a registered PC and resolves

---
 rtl/instruction_fetch_pkg.sv | 16 +
 rtl/instruction_fetch_if.sv | 21 ++
 rtl/instruction_fetch_decode.sv | 32 +++
 rtl/instruction_fetch.sv | 111 +++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and the control unit downstream of it.
// Holds the jump opcode, default widths and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int          OPC_W           = 4;
    localparam int          DEFAULT_INSTR_W = 32;
    localparam logic [OPC_W-1:0] OPC_JUMP   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Issue handshake between the fetch stage (master) and the control unit (slave).
interface instruction_fetch_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 4
);
    logic [INSTR_W-1:0] instr_out;
    logic [3:0]         opcode_out;
    logic               instr_valid;
    logic               instr_ready;
    logic [PC_W-1:0]    pc_out;

    modport master (
        output instr_out, opcode_out, instr_valid, pc_out,
        input  instr_ready
    );

    modport slave (
        input  instr_out, opcode_out, instr_valid, pc_out,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch_decode.sv
// Combinational word select and jump classification for the word at the current PC.
module instruction_fetch_decode
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH   = 10,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 4
) (
    input  logic [DEPTH*INSTR_W-1:0] program_addr_array,
    input  logic [PC_W-1:0]          pc,
    output logic [INSTR_W-1:0]       word,
    output logic                     is_zero,
    output logic                     is_jump,
    output logic [PC_W-1:0]          jump_tgt,
    output logic                     tgt_bad
);
    localparam logic [31:0] DEPTH_U = DEPTH;

    // A PC outside the image reads as zero, which halts the run.
    always_comb begin
        word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (pc == PC_W'(k)) word = program_addr_array[k*INSTR_W +: INSTR_W];
        end
    end

    assign is_zero  = (word == '0);
    assign is_jump  = (word[INSTR_W-1 -: OPC_W] == OPC_JUMP);
    assign jump_tgt = word[PC_W-1:0];
    assign tgt_bad  = (32'(jump_tgt) >= DEPTH_U);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: walks the program image, resolves jumps locally and issues each
// non-jump word to the control unit over a valid/ready handshake.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH     = 10,
    parameter int INSTR_W   = 32,
    parameter int PC_W      = 4,
    parameter int MAX_JUMPS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DEPTH*INSTR_W-1:0] program_addr_array,
    instruction_fetch_if.master      bus,
    output logic                     busy,
    output logic                     halted,
    output logic                     fault
);
    localparam int                JCNT_W    = $clog2(MAX_JUMPS + 1);
    localparam logic [JCNT_W-1:0] JCNT_LAST = JCNT_W'(MAX_JUMPS - 1);
    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(DEPTH - 1);

    fetch_state_t       state;
    logic [PC_W-1:0]    pc;
    logic [JCNT_W-1:0]  jcnt;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    logic [INSTR_W-1:0] word;
    logic               is_zero, is_jump, tgt_bad;
    logic [PC_W-1:0]    jump_tgt;

    instruction_fetch_decode #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_decode (
        .program_addr_array (program_addr_array),
        .pc                 (pc),
        .word               (word),
        .is_zero            (is_zero),
        .is_jump            (is_jump),
        .jump_tgt           (jump_tgt),
        .tgt_bad            (tgt_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= '0;
            jcnt    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc     <= '0;
                        jcnt   <= '0;
                        halted <= 1'b0;
                        fault  <= 1'b0;
                        state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (is_zero) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (is_jump) begin
                        // The jump guard counts consecutive jumps; any issue resets it.
                        if (tgt_bad || jcnt == JCNT_LAST) begin
                            fault <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            pc   <= jump_tgt;
                            jcnt <= jcnt + JCNT_W'(1);
                        end
                    end else begin
                        instr_q <= word;
                        valid_q <= 1'b1;
                        jcnt    <= '0;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (valid_q && bus.instr_ready) begin
                        valid_q <= 1'b0;
                        if (pc == PC_LAST) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc    <= pc + PC_W'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.opcode_out  = instr_q[INSTR_W-1 -: OPC_W];
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc;
    assign busy            = (state == ST_FETCH) || (state == ST_ISSUE);

endmodule
